// File: rtl/conf_sequencer_if.sv
// Handshake and configuration bus between the CPU register file, the
// conf_sequencer and the downstream mux dataflow controller.
interface conf_sequencer_if #(
  parameter int BITWIDTH_W_ROWS     = 4,
  parameter int BITWIDTH_W_COLUMS   = 4,
  parameter int BITWIDTH_MAX_W_SIZE = 9
) ();
  logic                           CONFSEQ_Start;
  logic [BITWIDTH_W_ROWS-1:0]     CONFSEQ_W_Rows;
  logic [BITWIDTH_W_COLUMS-1:0]   CONFSEQ_W_Colums;
  logic                           CONFSEQ_Muxdc_Set_Conf_Already;
  logic                           CONFSEQ_Muxdc_Set_Conf;
  logic                           CONFSEQ_Muxdc_Set_Conf_Already_Ok;
  logic [BITWIDTH_W_COLUMS-1:0]   CONFSEQ_W_Colums_Out;
  logic [BITWIDTH_MAX_W_SIZE-1:0] CONFSEQ_W_ROXCL;
  logic                           CONFSEQ_Busy;
  logic                           CONFSEQ_Done;
  logic                           CONFSEQ_Error;

  // Environment side: CPU registers plus the mux controller model.
  modport master (
    output CONFSEQ_Start, CONFSEQ_W_Rows, CONFSEQ_W_Colums,
           CONFSEQ_Muxdc_Set_Conf_Already,
    input  CONFSEQ_Muxdc_Set_Conf, CONFSEQ_Muxdc_Set_Conf_Already_Ok,
           CONFSEQ_W_Colums_Out, CONFSEQ_W_ROXCL,
           CONFSEQ_Busy, CONFSEQ_Done, CONFSEQ_Error
  );

  modport slave (
    input  CONFSEQ_Start, CONFSEQ_W_Rows, CONFSEQ_W_Colums,
           CONFSEQ_Muxdc_Set_Conf_Already,
    output CONFSEQ_Muxdc_Set_Conf, CONFSEQ_Muxdc_Set_Conf_Already_Ok,
           CONFSEQ_W_Colums_Out, CONFSEQ_W_ROXCL,
           CONFSEQ_Busy, CONFSEQ_Done, CONFSEQ_Error
  );
endinterface

// File: rtl/conf_sequencer.sv
// Kernel configuration sequencer: validates rows x columns by repeated
// addition, then runs a 4-phase handshake with the mux dataflow controller.
module conf_sequencer #(
  parameter int BITWIDTH_W_ROWS     = 4,
  parameter int BITWIDTH_W_COLUMS   = 4,
  parameter int BITWIDTH_MAX_W_SIZE = 9,
  parameter int MAX_TAPS            = 168,
  parameter int TIMEOUT             = 512
) (
  input  logic          CONFSEQ_Clk,
  input  logic          CONFSEQ_Reset,
  conf_sequencer_if.slave bus
);

  localparam int SUM_W = BITWIDTH_MAX_W_SIZE + 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]           TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [SUM_W-1:0]           TAPS_LIMIT = SUM_W'(MAX_TAPS);
  localparam logic [BITWIDTH_W_ROWS-1:0] ONE_ROW    = BITWIDTH_W_ROWS'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MULT, S_REQ, S_WAIT_ACK, S_RELEASE, S_DONE, S_ERR
  } state_e;

  state_e                         state_q, state_d;
  logic                           armed_q, armed_d;
  logic [BITWIDTH_W_ROWS-1:0]     rows_q, rows_d;
  logic [BITWIDTH_W_COLUMS-1:0]   cols_q, cols_d;
  logic [BITWIDTH_MAX_W_SIZE-1:0] acc_q, acc_d;
  logic [BITWIDTH_W_ROWS-1:0]     row_cnt_q, row_cnt_d;
  logic [TMO_W-1:0]               tmo_q, tmo_d;
  logic [BITWIDTH_MAX_W_SIZE-1:0] roxcl_q, roxcl_d;
  logic                           set_conf_q, set_conf_d;
  logic                           ok_q, ok_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           error_q, error_d;

  logic             accept;
  logic [SUM_W-1:0] sum;
  logic [TMO_W-1:0] tmo_next;

  // armed_q blocks a Start on the first edge after reset release.
  assign accept   = armed_q && bus.CONFSEQ_Start &&
                    (state_q inside {S_IDLE, S_DONE, S_ERR});
  // One spare bit so the overflow compare sees the true sum.
  assign sum      = {1'b0, acc_q} + SUM_W'(cols_q);
  assign tmo_next = tmo_q + TMO_W'(1);

  // NOTE: the reset branch is asynchronous (in the sensitivity list), and all
  // state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CONFSEQ_Clk or negedge CONFSEQ_Reset) begin
    if (!CONFSEQ_Reset) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      acc_q      <= '0;
      row_cnt_q  <= '0;
      tmo_q      <= '0;
      roxcl_q    <= '0;
      set_conf_q <= 1'b0;
      ok_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      acc_q      <= acc_d;
      row_cnt_q  <= row_cnt_d;
      tmo_q      <= tmo_d;
      roxcl_q    <= roxcl_d;
      set_conf_q <= set_conf_d;
      ok_q       <= ok_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // NOTE: every variable gets a hold-value default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    armed_d   = 1'b1;
    rows_d    = rows_q;
    cols_d    = cols_q;
    acc_d     = acc_q;
    row_cnt_d = row_cnt_q;
    tmo_d     = tmo_q;
    roxcl_d   = roxcl_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept) begin
          rows_d  = bus.CONFSEQ_W_Rows;
          cols_d  = bus.CONFSEQ_W_Colums;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rows_q == '0 || cols_q == '0) begin
          state_d = S_ERR;
        end else begin
          acc_d     = '0;
          row_cnt_d = '0;
          state_d   = S_MULT;
        end
      end
      S_MULT: begin
        acc_d     = sum[BITWIDTH_MAX_W_SIZE-1:0];
        row_cnt_d = row_cnt_q + ONE_ROW;
        if (sum > TAPS_LIMIT) begin
          state_d = S_ERR;
        end else if (row_cnt_q == rows_q - ONE_ROW) begin
          roxcl_d = sum[BITWIDTH_MAX_W_SIZE-1:0] - BITWIDTH_MAX_W_SIZE'(1);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        tmo_d = tmo_next;
        // An acknowledge in the terminal cycle still wins over the timeout.
        if (bus.CONFSEQ_Muxdc_Set_Conf_Already) begin
          state_d = S_RELEASE;
        end else if (tmo_next == TMO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_RELEASE: begin
        if (!bus.CONFSEQ_Muxdc_Set_Conf_Already) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered Moore outputs: each follows the state one cycle later.
  always_comb begin
    set_conf_d = (state_q == S_REQ);
    ok_d       = (state_q == S_RELEASE);
    busy_d     = state_q inside {S_CHECK, S_MULT, S_REQ, S_WAIT_ACK, S_RELEASE};
    done_d     = (state_q == S_DONE) && !accept;
    error_d    = (state_q == S_ERR) && !accept;
  end

  assign bus.CONFSEQ_Muxdc_Set_Conf            = set_conf_q;
  assign bus.CONFSEQ_Muxdc_Set_Conf_Already_Ok = ok_q;
  assign bus.CONFSEQ_W_Colums_Out              = cols_q;
  assign bus.CONFSEQ_W_ROXCL                   = roxcl_q;
  assign bus.CONFSEQ_Busy                      = busy_q;
  assign bus.CONFSEQ_Done                      = done_q;
  assign bus.CONFSEQ_Error                     = error_q;

endmodule
